pll_lock_reset_seq: RTL and testbench

//  Downstream companion of the USB-host EHXPLLL clock generator. It consumes the raw PLL lock

---
 rtl/pll_lock_reset_seq.sv | 163 ++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the USB-host PLL: waits for stable lock, releases the PHY reset and then
// the core reset, retries the PLL via its RST pin when lock never arrives, and parks in FAIL.
module pll_lock_reset_seq #(
  parameter int unsigned LOCK_CYCLES   = 1024,
  parameter int unsigned PHY_DELAY     = 256,
  parameter int unsigned TIMEOUT       = 65536,
  parameter int unsigned PLLRST_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 4,
  parameter int unsigned CNT_W         = 17
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       locked_i,
  input  logic       retry_i,
  output logic       pll_rst_o,
  output logic       phy_rst_o,
  output logic       core_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] retry_cnt_o,
  output logic [7:0] lost_cnt_o
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PLLRST,
    ST_STABLE,
    ST_PHY,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_LAST     = CNT_W'(PHY_DELAY - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRY);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s1;
  logic             lock_s2;

  // Two-flop synchronizer; the FSM only ever looks at lock_s2.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the two stages into one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= locked_i;
      lock_s2 <= lock_s1;
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Outputs are updated on the same edge as the transition that changes them, so they come
  // straight from flops and cannot glitch; phy_rst_o always falls a full PHY_DELAY before core.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_WAIT;
      cnt         <= '0;
      pll_rst_o   <= 1'b0;
      phy_rst_o   <= 1'b1;
      core_rst_o  <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
      retry_cnt_o <= 3'd0;
      lost_cnt_o  <= 8'd0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      unique case (state)
        ST_WAIT: begin
          if (lock_s2) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_cnt_o == RETRY_LIMIT) begin
              state  <= ST_FAIL;
              fail_o <= 1'b1;
            end else begin
              state       <= ST_PLLRST;
              pll_rst_o   <= 1'b1;
              retry_cnt_o <= retry_cnt_o + 3'd1;
            end
          end
        end

        ST_PLLRST: begin
          if (cnt == PLLRST_LAST) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            pll_rst_o <= 1'b0;
          end
        end

        // Lock loss is tested before count expiry so a drop on the last cycle wins.
        ST_STABLE: begin
          if (!lock_s2) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state     <= ST_PHY;
            cnt       <= '0;
            phy_rst_o <= 1'b0;
          end
        end

        ST_PHY: begin
          if (!lock_s2) begin
            state      <= ST_WAIT;
            cnt        <= '0;
            phy_rst_o  <= 1'b1;
            lost_cnt_o <= sat_inc(lost_cnt_o);
          end else if (cnt == PHY_LAST) begin
            state       <= ST_RUN;
            cnt         <= '0;
            core_rst_o  <= 1'b0;
            ready_o     <= 1'b1;
            retry_cnt_o <= 3'd0;
          end
        end

        ST_RUN: begin
          if (!lock_s2) begin
            state      <= ST_WAIT;
            cnt        <= '0;
            phy_rst_o  <= 1'b1;
            core_rst_o <= 1'b1;
            ready_o    <= 1'b0;
            lost_cnt_o <= sat_inc(lost_cnt_o);
          end
        end

        ST_FAIL: begin
          if (retry_i) begin
            state       <= ST_PLLRST;
            cnt         <= '0;
            fail_o      <= 1'b0;
            pll_rst_o   <= 1'b1;
            retry_cnt_o <= 3'd0;
          end
        end

        default: begin
          state      <= ST_WAIT;
          cnt        <= '0;
          pll_rst_o  <= 1'b0;
          phy_rst_o  <= 1'b1;
          core_rst_o <= 1'b1;
          ready_o    <= 1'b0;
          fail_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with small parameters; expected output vectors are
// queued as stimulus is applied and popped when the DUT output is sampled on the falling edge.
module tb_pll_lock_reset_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       locked;
  logic       retry;
  logic       pll_rst;
  logic       phy_rst;
  logic       core_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] lost_cnt;

  pll_lock_reset_seq #(
    .LOCK_CYCLES  (8),
    .PHY_DELAY    (4),
    .TIMEOUT      (32),
    .PLLRST_CYCLES(3),
    .MAX_RETRY    (2),
    .CNT_W        (17)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .locked_i   (locked),
    .retry_i    (retry),
    .pll_rst_o  (pll_rst),
    .phy_rst_o  (phy_rst),
    .core_rst_o (core_rst),
    .ready_o    (ready),
    .fail_o     (fail),
    .retry_cnt_o(retry_cnt),
    .lost_cnt_o (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  typedef struct {
    int          at;
    logic [15:0] v;
  } step_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cur_edge    = 0;
  int   exp_lost    = 0;

  // Packed order: pll, phy, core, ready, fail, retry_cnt[2:0], lost_cnt[7:0].
  function automatic logic [15:0] vec(input bit p, input bit ph, input bit c, input bit r,
                                      input bit f, input int rc, input int lc);
    return {p, ph, c, r, f, 3'(rc), 8'(lc)};
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    obs = {pll_rst, phy_rst, core_rst, ready, fail, retry_cnt, lost_cnt};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v)
      else begin
        miscompares++;
        $error("FAIL %s (edge %0d): observed %h expected %h", e.tag, cur_edge, obs, e.v);
      end
    end
  endtask

  // Advance to the falling edge that follows rising edge t (counted from reset release).
  task automatic goto(input int t);
    repeat (t - cur_edge) @(negedge clk);
    cur_edge = t;
  endtask

  step_t t4[10];
  step_t t5[7];

  initial begin
    rstn   = 1'b0;
    locked = 1'b0;
    retry  = 1'b0;
    repeat (3) @(negedge clk);
    push("reset_values", vec(0, 1, 1, 0, 0, 0, 0));
    check();
    rstn     = 1'b1;
    cur_edge = 0;

    // Lock arrives before edge 3: STABLE at 5, PHY release at 13, RUN at 17.
    goto(2);
    locked = 1'b1;
    push("t1_phy_held",   vec(0, 1, 1, 0, 0, 0, 0));
    push("t1_phy_rel",    vec(0, 0, 1, 0, 0, 0, 0));
    push("t1_core_held",  vec(0, 0, 1, 0, 0, 0, 0));
    push("t1_run",        vec(0, 0, 0, 1, 0, 0, 0));
    goto(12); check();
    goto(13); check();
    goto(16); check();
    goto(17); check();

    // Lock drops before edge 21 while in RUN: both resets back at 23, lost count 1.
    goto(20);
    locked = 1'b0;
    push("t2_run_still",  vec(0, 0, 0, 1, 0, 0, 0));
    push("t2_lost",       vec(0, 1, 1, 0, 0, 0, 1));
    goto(22); check();
    goto(23); check();

    // Five-cycle lock glitch seen in STABLE: PHY reset must never release.
    locked = 1'b1;
    for (int e = 24; e <= 35; e++) begin
      push($sformatf("t3_glitch_%0d", e), vec(0, 1, 1, 0, 0, 0, 1));
      goto(e);
      check();
      if (e == 28) locked = 1'b0;
    end

    // Asynchronous reset clears everything including the lost counter.
    #2 rstn = 1'b0;
    #1 push("reset_clears_lost", vec(0, 1, 1, 0, 0, 0, 0));
    check();
    @(negedge clk);
    rstn     = 1'b1;
    cur_edge = 0;

    // Lock never arrives: PLL resets at 32 and 67, FAIL at 102.
    t4[0] = '{31,  vec(0, 1, 1, 0, 0, 0, 0)};
    t4[1] = '{32,  vec(1, 1, 1, 0, 0, 1, 0)};
    t4[2] = '{34,  vec(1, 1, 1, 0, 0, 1, 0)};
    t4[3] = '{35,  vec(0, 1, 1, 0, 0, 1, 0)};
    t4[4] = '{66,  vec(0, 1, 1, 0, 0, 1, 0)};
    t4[5] = '{67,  vec(1, 1, 1, 0, 0, 2, 0)};
    t4[6] = '{69,  vec(1, 1, 1, 0, 0, 2, 0)};
    t4[7] = '{70,  vec(0, 1, 1, 0, 0, 2, 0)};
    t4[8] = '{101, vec(0, 1, 1, 0, 0, 2, 0)};
    t4[9] = '{102, vec(0, 1, 1, 0, 1, 2, 0)};
    for (int i = 0; i < 10; i++) begin
      push($sformatf("t4_timeout_%0d", t4[i].at), t4[i].v);
      goto(t4[i].at);
      check();
    end

    // FAIL is sticky until retry_i; then lock leads to a normal RUN at 119.
    retry  = 1'b1;
    locked = 1'b1;
    t5[0] = '{103, vec(1, 1, 1, 0, 0, 0, 0)};
    t5[1] = '{105, vec(1, 1, 1, 0, 0, 0, 0)};
    t5[2] = '{106, vec(0, 1, 1, 0, 0, 0, 0)};
    t5[3] = '{114, vec(0, 1, 1, 0, 0, 0, 0)};
    t5[4] = '{115, vec(0, 0, 1, 0, 0, 0, 0)};
    t5[5] = '{118, vec(0, 0, 1, 0, 0, 0, 0)};
    t5[6] = '{119, vec(0, 0, 0, 1, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      push($sformatf("t5_retry_%0d", t5[i].at), t5[i].v);
      goto(t5[i].at);
      retry = 1'b0;
      check();
    end

    // retry_i outside FAIL has no effect.
    retry = 1'b1;
    push("retry_ignored_in_run", vec(0, 0, 0, 1, 0, 0, 0));
    goto(cur_edge + 1);
    retry = 1'b0;
    check();

    // 300 lock losses from RUN: counter saturates at 255.
    exp_lost = 0;
    for (int i = 0; i < 300; i++) begin
      locked   = 1'b0;
      exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
      push("t6_drop", vec(0, 1, 1, 0, 0, 0, exp_lost));
      goto(cur_edge + 3);
      check();
      locked = 1'b1;
      push("t6_relock_run", vec(0, 0, 0, 1, 0, 0, exp_lost));
      goto(cur_edge + 15);
      check();
    end

    // Reset asserted in the middle of PHY returns every output to its reset value.
    locked = 1'b0;
    goto(cur_edge + 3);
    locked = 1'b1;
    push("t6_in_phy", vec(0, 0, 1, 0, 0, 0, 255));
    goto(cur_edge + 12);
    check();
    #2 rstn = 1'b0;
    #1 push("t6_reset_mid_phy", vec(0, 1, 1, 0, 0, 0, 0));
    check();
    @(negedge clk);
    rstn = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
